// File: rtl/arbitro_memoria.sv
// -----------------------------------------------------------------------------
// arbitro_memoria
// Arbiter that shares one single-port synchronous memory between an
// instruction-fetch port (read only) and a data port (load/store).
// A transaction is IDLE -> ISSUE -> [WAIT x WAIT_CYCLES] -> ACK -> IDLE.
// Stores skip WAIT. Ties are broken round-robin.
//
// Ports
//   clock, reset        clock (rising edge), asynchronous active-high reset
//   f_req, f_addr       fetch request and byte address
//   f_ack, f_rdata      fetch completion pulse and registered read data
//   d_req, d_we         data request, 1 = store / 0 = load
//   d_addr, d_wdata     data byte address and store data
//   d_ack, d_rdata      data completion pulse and registered load data
//   mem_addr/wdata/we   memory address, write data and write enable
//   mem_rdata           memory read data, valid WAIT_CYCLES after address cycle
//   busy, state         FSM not idle, FSM state (IDLE=0 ISSUE=1 WAIT=2 ACK=3)
// -----------------------------------------------------------------------------
module arbitro_memoria #(
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        f_req,
   input  logic [31:0] f_addr,
   output logic        f_ack,
   output logic [31:0] f_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_ack,
   output logic [31:0] d_rdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_we,
   input  logic [31:0] mem_rdata,
   output logic        busy,
   output logic [1:0]  state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_ACK   = 2'd3
   } t_state;

   localparam logic [3:0] LP_LAST = 4'(WAIT_CYCLES - 1);

   t_state      r_state;
   t_state      w_next;
   logic        w_grant;
   logic        w_pick_d;
   logic        w_last_wait;
   // r_gnt_d is the current grant while busy and the last grant while idle
   logic        r_gnt_d;
   logic        r_we;
   logic [3:0]  r_cnt;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_frd;
   logic [31:0] r_drd;

   assign w_last_wait = (r_state == S_WAIT) && (r_cnt == LP_LAST);

   always_comb begin
      w_next   = r_state;
      w_grant  = 1'b0;
      w_pick_d = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (f_req || d_req) begin
               w_grant  = 1'b1;
               // On a tie the data port wins unless it was granted last
               w_pick_d = d_req && (!f_req || !r_gnt_d);
               w_next   = S_ISSUE;
            end
         end
         S_ISSUE: w_next = r_we ? S_ACK : S_WAIT;
         S_WAIT:  if (w_last_wait) w_next = S_ACK;
         S_ACK:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_gnt_d <= 1'b0;
         r_we    <= 1'b0;
         r_cnt   <= 4'd0;
         r_addr  <= 32'd0;
         r_wdata <= 32'd0;
         r_frd   <= 32'd0;
         r_drd   <= 32'd0;
      end else begin
         r_state <= w_next;
         if (w_grant) begin
            r_gnt_d <= w_pick_d;
            r_we    <= w_pick_d && d_we;
            r_addr  <= w_pick_d ? d_addr : f_addr;
            // Fetches carry no write data; drive zero rather than stale data
            r_wdata <= w_pick_d ? d_wdata : 32'd0;
         end
         if (r_state == S_ISSUE)
            r_cnt <= 4'd0;
         else if ((r_state == S_WAIT) && !w_last_wait)
            r_cnt <= r_cnt + 4'd1;
         // Only the granted requester's read register is updated
         if (w_last_wait) begin
            if (r_gnt_d) r_drd <= mem_rdata;
            else         r_frd <= mem_rdata;
         end
      end
   end

   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign mem_we    = (r_state == S_ISSUE) && r_we;
   assign f_ack     = (r_state == S_ACK) && !r_gnt_d;
   assign d_ack     = (r_state == S_ACK) && r_gnt_d;
   assign f_rdata   = r_frd;
   assign d_rdata   = r_drd;
   assign busy      = (r_state != S_IDLE);
   assign state     = r_state;

endmodule
